get_money: RTL and testbench



---
 rtl/get_money.sv | 109 ++++++++++
 tb/tb_get_money.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/get_money.sv
// Coin-acceptance and credit register: accumulates coin credit, debits purchases, refunds on mode=1.
// Define GET_MONEY_COIN5_EN to accept coin_in=11 as a 5-unit coin; otherwise it is always rejected.
module get_money #(
    parameter int MAX_CREDIT = 15
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       mode,
    input  logic [1:0] coin_in,
    input  logic       spend,
    input  logic [3:0] spend_amount,
    output logic [3:0] value,
    output logic       spend_ok,
    output logic       spend_err,
    output logic       coin_reject,
    output logic       refund_valid,
    output logic [3:0] refund_amount
);
    localparam logic [4:0] MAX_C = 5'(MAX_CREDIT);

    logic [3:0] value_q, value_d;
    logic       spend_ok_q, spend_ok_d;
    logic       spend_err_q, spend_err_d;
    logic       coin_rej_q, coin_rej_d;
    logic       refund_vld_q, refund_vld_d;
    logic [3:0] refund_amt_q, refund_amt_d;

    logic [2:0] coin_val;
    logic       coin_bad;
    logic [3:0] v_after_spend;
    logic [4:0] coin_sum;

    always_comb begin
        coin_val = 3'd0;
        coin_bad = 1'b0;
        case (coin_in)
            2'b01:   coin_val = 3'd1;
            2'b10:   coin_val = 3'd2;
`ifdef GET_MONEY_COIN5_EN
            2'b11:   coin_val = 3'd5;
`else
            2'b11:   coin_bad = 1'b1;
`endif
            default: coin_val = 3'd0;
        endcase
    end

    always_comb begin
        value_d       = value_q;
        spend_ok_d    = 1'b0;
        spend_err_d   = 1'b0;
        coin_rej_d    = 1'b0;
        refund_vld_d  = 1'b0;
        refund_amt_d  = 4'd0;
        v_after_spend = value_q;
        coin_sum      = 5'd0;
        if (mode) begin
            // Refund wins over everything else on this edge; coins and purchases bounce.
            if (value_q != 4'd0) begin
                refund_vld_d = 1'b1;
                refund_amt_d = value_q;
                value_d      = 4'd0;
            end
            coin_rej_d  = (coin_in != 2'b00);
            spend_err_d = spend;
        end else begin
            if (spend) begin
                if (spend_amount <= value_q && spend_amount != 4'd0) begin
                    v_after_spend = value_q - spend_amount;
                    spend_ok_d    = 1'b1;
                end else begin
                    spend_err_d = 1'b1;
                end
            end
            // Coin is credited against the post-debit credit; 5-bit sum keeps overflow visible.
            coin_sum = {1'b0, v_after_spend} + {2'b00, coin_val};
            value_d  = v_after_spend;
            if (coin_in != 2'b00) begin
                if (!coin_bad && coin_sum <= MAX_C) value_d = coin_sum[3:0];
                else coin_rej_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value_q      <= 4'd0;
            spend_ok_q   <= 1'b0;
            spend_err_q  <= 1'b0;
            coin_rej_q   <= 1'b0;
            refund_vld_q <= 1'b0;
            refund_amt_q <= 4'd0;
        end else begin
            value_q      <= value_d;
            spend_ok_q   <= spend_ok_d;
            spend_err_q  <= spend_err_d;
            coin_rej_q   <= coin_rej_d;
            refund_vld_q <= refund_vld_d;
            refund_amt_q <= refund_amt_d;
        end
    end

    assign value         = value_q;
    assign spend_ok      = spend_ok_q;
    assign spend_err     = spend_err_q;
    assign coin_reject   = coin_rej_q;
    assign refund_valid  = refund_vld_q;
    assign refund_amount = refund_amt_q;
endmodule

// File: tb/tb_get_money.sv
// Directed + random bench for get_money; expectations queued at drive time, checked after the edge.
module tb_get_money;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] coin_in = 2'b00;
    logic       spend = 1'b0;
    logic [3:0] spend_amount = 4'd0;
    logic [3:0] value;
    logic       spend_ok, spend_err, coin_reject, refund_valid;
    logic [3:0] refund_amount;

    typedef struct packed {
        logic [3:0] value;
        logic       ok;
        logic       err;
        logic       rej;
        logic       rv;
        logic [3:0] ra;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   mv = 0;

    get_money #(.MAX_CREDIT(15)) dut (
        .clock(clock), .reset_n(reset_n), .mode(mode), .coin_in(coin_in),
        .spend(spend), .spend_amount(spend_amount), .value(value),
        .spend_ok(spend_ok), .spend_err(spend_err), .coin_reject(coin_reject),
        .refund_valid(refund_valid), .refund_amount(refund_amount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour in plain integer arithmetic.
    task automatic step(input logic m, input logic [1:0] c, input logic s, input int amt);
        exp_t e;
        int cv, v1;
        logic bad;
        @(negedge clock);
        mode = m; coin_in = c; spend = s; spend_amount = 4'(amt);
        e = '0;
        bad = 1'b0;
        case (c)
            2'b01: cv = 1;
            2'b10: cv = 2;
`ifdef GET_MONEY_COIN5_EN
            2'b11: cv = 5;
`else
            2'b11: begin cv = 0; bad = 1'b1; end
`endif
            default: cv = 0;
        endcase
        if (m) begin
            if (mv > 0) begin e.rv = 1'b1; e.ra = 4'(mv); end
            mv = 0;
            e.rej = (c != 0);
            e.err = s;
        end else begin
            v1 = mv;
            if (s) begin
                if (amt <= mv && amt != 0) begin v1 = mv - amt; e.ok = 1'b1; end
                else e.err = 1'b1;
            end
            mv = v1;
            if (c != 0) begin
                if (!bad && v1 + cv <= 15) mv = v1 + cv;
                else e.rej = 1'b1;
            end
        end
        e.value = 4'(mv);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        check_out();
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard: got empty queue expected entry");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("value", value, e.value);
            chk("spend_ok", spend_ok, e.ok);
            chk("spend_err", spend_err, e.err);
            chk("coin_reject", coin_reject, e.rej);
            chk("refund_valid", refund_valid, e.rv);
            chk("refund_amount", refund_amount, e.ra);
        end
    endtask

    initial begin
        #12;
        chk("rst value", value, 0);
        chk("rst refund_valid", refund_valid, 0);
        chk("rst flags", {spend_ok, spend_err, coin_reject}, 0);
        chk("rst refund_amount", refund_amount, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic accumulation and a single refund; holding mode=1 refunds only once.
        step(0, 2'b01, 0, 0); chk("tp value=1", value, 1);
        step(0, 2'b10, 0, 0); chk("tp value=3", value, 3);
        step(0, 2'b01, 0, 0); chk("tp value=4", value, 4);
        step(1, 2'b00, 0, 0); chk("tp refund=4", refund_amount, 4);
        step(1, 2'b00, 1, 3); chk("tp no 2nd refund", refund_valid, 0);

        // Overflow boundary at 14/15.
        repeat (7) step(0, 2'b10, 0, 0);
        chk("tp value=14", value, 14);
        step(0, 2'b10, 0, 0); chk("tp reject at 14", coin_reject, 1);
        step(0, 2'b01, 0, 0); chk("tp value=15", value, 15);
        step(0, 2'b01, 0, 0); chk("tp reject at 15", coin_reject, 1);
        step(0, 2'b00, 1, 15); chk("spend all", value, 0);

        // Spend boundaries.
        repeat (3) step(0, 2'b10, 0, 0);
        step(0, 2'b00, 1, 7); chk("tp spend 7 err", spend_err, 1);
        step(0, 2'b00, 1, 6); chk("tp spend 6 ok", spend_ok, 1);
        step(0, 2'b00, 1, 0); chk("spend 0 err", spend_err, 1);

        // Simultaneous spend + coin at 15, then refund with coin.
        repeat (7) step(0, 2'b10, 0, 0);
        step(0, 2'b01, 0, 0);
        step(0, 2'b11, 1, 5);
        step(0, 2'b01, 1, 2);
        step(1, 2'b01, 1, 1); chk("refund with coin rej", coin_reject, 1);

        // 5-unit coin code at zero credit, in both modes.
        step(0, 2'b11, 0, 0);
        step(1, 2'b11, 0, 0);
        step(1, 2'b00, 0, 0);

        // Random traffic, mode biased towards accept.
        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));

        // Asynchronous reset at credit 9 between edges.
        step(1, 2'b00, 0, 0);
        repeat (4) step(0, 2'b10, 0, 0);
        step(0, 2'b01, 0, 0);
        chk("pre-reset value=9", value, 9);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst value", value, 0);
        chk("async rst refund_valid", refund_valid, 0);
        mv = 0;
        @(negedge clock);
        mode = 0; coin_in = 0; spend = 0;
        @(negedge clock);
        reset_n = 1'b1;
        step(0, 2'b00, 0, 0);
        chk("post-reset idle", value, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
